// File: rtl/beta_lane_sequencer.sv
// ============================================================================
// Module  : beta_lane_sequencer
// Purpose : Area-reduced SWAN128 beta (S-box) layer. Substitutes the 16
//           bit-sliced 4-bit columns of a 64-bit half-state, LANES columns
//           per clock, using only LANES sbox instances.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module beta_lane_sequencer #(
  parameter int BLOCK_SIZE  = 128,
  parameter int SIDE_SIZE   = BLOCK_SIZE / 2,
  parameter int COLUMN_SIZE = SIDE_SIZE / 4,
  parameter int SBOX_SIZE   = 4,
  parameter int LANES       = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [0:SIDE_SIZE-1] x,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [0:SIDE_SIZE-1] y,
  output logic                 busy
);

  // Elaboration-time guard on the configuration space.
  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
    $error("beta_lane_sequencer: LANES must be one of 1, 2, 4, 8, 16");
  end
  if (SIDE_SIZE != 64 || SBOX_SIZE != 4 || COLUMN_SIZE != 16) begin : g_bad_geometry
    $error("beta_lane_sequencer: only the 64-bit / 4-bit / 16-column geometry is supported");
  end

  // col_cnt advance per RUN cycle; LANES=16 wraps to a zero step (single RUN cycle).
  localparam logic [3:0] STEP = 4'(LANES % COLUMN_SIZE);
  // Value of col_cnt during the cycle that processes column 15.
  localparam logic [3:0] LAST = 4'(COLUMN_SIZE - LANES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state, state_next;
  logic [3:0]           col_cnt, col_cnt_next;
  logic [0:SIDE_SIZE-1] work, work_next, sub_work;

  logic [3:0]           lane_col [LANES];
  logic [SBOX_SIZE-1:0] lane_in  [LANES];
  logic [SBOX_SIZE-1:0] lane_out [LANES];

  // 4-bit substitution table; input bit 3 is the column's top-row bit.
  function automatic logic [3:0] sbox(input logic [3:0] v);
    logic [3:0] r;
    case (v)
      4'h0: r = 4'hC;
      4'h1: r = 4'h5;
      4'h2: r = 4'h6;
      4'h3: r = 4'hB;
      4'h4: r = 4'h9;
      4'h5: r = 4'h0;
      4'h6: r = 4'hA;
      4'h7: r = 4'hD;
      4'h8: r = 4'h3;
      4'h9: r = 4'hE;
      4'hA: r = 4'hF;
      4'hB: r = 4'h8;
      4'hC: r = 4'h4;
      4'hD: r = 4'h7;
      4'hE: r = 4'h1;
      default: r = 4'h2;
    endcase
    return r;
  endfunction

  // One sbox per lane; lane k gathers column col_cnt+k from the work register.
  // col_cnt is always a multiple of LANES, so col_cnt+k never overflows 4 bits.
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    assign lane_col[k] = col_cnt + 4'(k);
    assign lane_in[k]  = {work[{2'b00, lane_col[k]}], work[{2'b01, lane_col[k]}],
                          work[{2'b10, lane_col[k]}], work[{2'b11, lane_col[k]}]};
    assign lane_out[k] = sbox(lane_in[k]);
  end

  // Scatter the lane results back into their columns; other columns pass through.
  always_comb begin
    sub_work = work;
    for (int k = 0; k < LANES; k++) begin
      sub_work[{2'b00, lane_col[k]}] = lane_out[k][3];
      sub_work[{2'b01, lane_col[k]}] = lane_out[k][2];
      sub_work[{2'b10, lane_col[k]}] = lane_out[k][1];
      sub_work[{2'b11, lane_col[k]}] = lane_out[k][0];
    end
  end

  // Next-state logic: accept in IDLE, sweep columns in RUN, hand off in DONE.
  always_comb begin
    state_next   = state;
    col_cnt_next = col_cnt;
    work_next    = work;
    case (state)
      IDLE: begin
        if (in_valid) begin
          work_next    = x;
          col_cnt_next = 4'd0;
          state_next   = RUN;
        end
      end
      RUN: begin
        work_next    = sub_work;
        col_cnt_next = col_cnt + STEP;
        if (col_cnt == LAST) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State, column counter and work register; reset drops any in-flight block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      col_cnt <= 4'd0;
      work    <= '0;
    end else begin
      state   <= state_next;
      col_cnt <= col_cnt_next;
      work    <= work_next;
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign y         = work;

endmodule

`default_nettype wire

// File: tb/tb_beta_lane_sequencer.sv
// ============================================================================
// Module  : tb_beta_lane_sequencer
// Purpose : Scoreboard bench for beta_lane_sequencer across LANES=1..16.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_beta_lane_sequencer;

  localparam int N = 5;   // instance g has LANES = 1 << g

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        in_valid_a  [N];
  logic        in_ready_a  [N];
  logic        out_valid_a [N];
  logic        out_ready_a [N];
  logic        busy_a      [N];
  logic [0:63] x_a         [N];
  logic [0:63] y_a         [N];

  for (genvar g = 0; g < N; g++) begin : g_dut
    beta_lane_sequencer #(.LANES(1 << g)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid_a[g]),
      .in_ready  (in_ready_a[g]),
      .x         (x_a[g]),
      .out_valid (out_valid_a[g]),
      .out_ready (out_ready_a[g]),
      .y         (y_a[g]),
      .busy      (busy_a[g])
    );
  end

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          inst;
    logic [0:63] val;
  } exp_t;
  exp_t exp_q [$];

  localparam logic [3:0] SB [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                                     4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};

  // Fully parallel beta layer: every column substituted at once.
  function automatic logic [0:63] beta_model(input logic [0:63] v);
    logic [0:63] r;
    logic [3:0]  nib, s;
    r = v;
    for (int c = 0; c < 16; c++) begin
      nib = {v[c], v[16+c], v[32+c], v[48+c]};
      s   = SB[nib];
      r[c] = s[3]; r[16+c] = s[2]; r[32+c] = s[1]; r[48+c] = s[0];
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=timeout required=event", name);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int i, input logic [0:63] v);
    exp_t e;
    e.inst = i;
    e.val  = beta_model(v);
    exp_q.push_back(e);
  endtask

  task automatic wait_ready(input int i);
    int n = 0;
    while (!in_ready_a[i] && n < 60) begin
      tick();
      n++;
    end
    if (!in_ready_a[i]) timeout("wait_in_ready");
  endtask

  // Monitor: every output handshake pops the oldest expectation.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n) begin
      for (int i = 0; i < N; i++) begin
        if (out_valid_a[i] && out_ready_a[i]) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL out_unexpected inst=%0d actual=%h required=none", i, y_a[i]);
          end else begin
            e = exp_q.pop_front();
            chk("out_inst", 64'(i), 64'(e.inst));
            chk("out_y", y_a[i], e.val);
          end
        end
      end
    end
  end

  // One block with out_ready high; checks latency and in_ready/busy behaviour.
  task automatic run_one(input int i, input logic [0:63] v, input bit chk_ready);
    int n;
    wait_ready(i);
    out_ready_a[i] = 1'b1;
    x_a[i]         = v;
    in_valid_a[i]  = 1'b1;
    push_exp(i, v);
    tick();
    in_valid_a[i] = 1'b0;
    x_a[i]        = {$urandom, $urandom};
    n = 1;
    while (!out_valid_a[i] && n < 40) begin
      if (chk_ready) chk("in_ready_low_run", 64'(in_ready_a[i]), 64'd0);
      tick();
      n++;
    end
    if (!out_valid_a[i]) begin
      timeout("out_valid_wait");
    end else begin
      chk("latency", 64'(n), 64'(16 / (1 << i) + 1));
      chk("in_ready_low_done", 64'(in_ready_a[i]), 64'd0);
    end
    tick();
    chk("busy_after_out", 64'(busy_a[i]), 64'd0);
  endtask

  logic [0:63] v;
  logic [0:63] pats [3];

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int n;
    for (int i = 0; i < N; i++) begin
      in_valid_a[i]  = 1'b0;
      out_ready_a[i] = 1'b0;
      x_a[i]         = '0;
    end
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < N; i++) begin
      chk("rst_in_ready", 64'(in_ready_a[i]), 64'd1);
      chk("rst_out_valid", 64'(out_valid_a[i]), 64'd0);
      chk("rst_busy", 64'(busy_a[i]), 64'd0);
      chk("rst_y", y_a[i], 64'd0);
    end
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Latency on LANES=1 with the reference vector.
    run_one(0, 64'h0123456789ABCDEF, 1'b1);

    // Lane sweep.
    pats[0] = 64'h0;
    pats[1] = 64'hFFFFFFFFFFFFFFFF;
    pats[2] = 64'h8000000000000001;
    for (int i = 0; i < N; i++)
      for (int p = 0; p < 3; p++)
        run_one(i, pats[p], 1'b1);

    // Column isolation: single bit in row 1 of column c.
    for (int c = 0; c < 16; c++) begin
      v = '0;
      v[16+c] = 1'b1;
      run_one(c % N, v, 1'b0);
    end

    // Reset mid-RUN at col_cnt=7 on LANES=1.
    wait_ready(0);
    out_ready_a[0] = 1'b1;
    x_a[0]         = 64'hDEADBEEFCAFEF00D;
    in_valid_a[0]  = 1'b1;
    tick();
    in_valid_a[0]  = 1'b0;
    repeat (7) tick();
    rst_n = 1'b0;
    #1;
    chk("midrun_rst_out_valid", 64'(out_valid_a[0]), 64'd0);
    chk("midrun_rst_in_ready", 64'(in_ready_a[0]), 64'd1);
    chk("midrun_rst_busy", 64'(busy_a[0]), 64'd0);
    chk("midrun_rst_y", y_a[0], 64'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    run_one(0, 64'hDEADBEEFCAFEF00D, 1'b0);

    // Backpressure in DONE.
    v = {$urandom, $urandom};
    wait_ready(0);
    out_ready_a[0] = 1'b0;
    x_a[0]         = v;
    in_valid_a[0]  = 1'b1;
    push_exp(0, v);
    tick();
    in_valid_a[0] = 1'b0;
    n = 0;
    while (!out_valid_a[0] && n < 40) begin
      tick();
      n++;
    end
    if (!out_valid_a[0]) timeout("bp_out_valid_wait");
    for (int k = 0; k < 10; k++) begin
      chk("bp_out_valid", 64'(out_valid_a[0]), 64'd1);
      chk("bp_y_stable", y_a[0], beta_model(v));
      chk("bp_in_ready", 64'(in_ready_a[0]), 64'd0);
      in_valid_a[0] = (k == 4);
      x_a[0]        = ~v;
      tick();
    end
    in_valid_a[0]  = 1'b0;
    out_ready_a[0] = 1'b1;
    tick();
    chk("bp_release_out_valid", 64'(out_valid_a[0]), 64'd0);
    chk("bp_release_in_ready", 64'(in_ready_a[0]), 64'd1);

    // Back-to-back: in_valid held high, random out_ready.
    for (int b = 0; b < 100; b++) begin
      n = 0;
      while (!in_ready_a[0] && n < 60) begin
        out_ready_a[0] = 1'($urandom);
        tick();
        n++;
      end
      if (!in_ready_a[0]) timeout("b2b_in_ready");
      v             = {$urandom, $urandom};
      x_a[0]        = v;
      in_valid_a[0] = 1'b1;
      push_exp(0, v);
      out_ready_a[0] = 1'($urandom);
      tick();
    end
    in_valid_a[0]  = 1'b0;
    out_ready_a[0] = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      tick();
      n++;
    end
    if (exp_q.size() != 0) timeout("drain_scoreboard");
    repeat (3) tick();
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
